// File: rtl/coin_accumulator.sv
// coin_accumulator
// Sequential credit accumulator for the vending datapath. Accepts one coin
// per cycle, keeps the running credit in cents, tracks a decimal-packed
// per-denomination coin count, and handles vend and cancel requests. Any
// change due is presented on a valid/ack handshake.
//
// Ports:
//   clk, rst       - system clock, asynchronous active-high reset
//   coin_valid     - a coin of denomination coin_type is presented
//   coin_type      - 00 nickel, 01 dime, 10 quarter, 11 dollar
//   cancel         - return all credit as change
//   vend_req       - purchase request at price (cents)
//   change_ack     - downstream has taken change_cents
//   credit         - current credit in cents
//   coin_count     - D*1000 + Q*100 + d*10 + N, each digit saturating at 9
//   coin_accept    - one-cycle pulse: coin added to credit
//   coin_reject    - one-cycle pulse: coin refused
//   vend_ok        - one-cycle pulse: vend granted
//   vend_fail      - one-cycle pulse: vend refused
//   change_valid   - change_cents valid, held until acked
//   change_cents   - change amount in cents
//   busy           - high while change is pending
module coin_accumulator #(
    parameter int unsigned MAX_CENTS = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        coin_valid,
    input  logic [1:0]  coin_type,
    input  logic        cancel,
    input  logic        vend_req,
    input  logic [8:0]  price,
    input  logic        change_ack,
    output logic [8:0]  credit,
    output logic [13:0] coin_count,
    output logic        coin_accept,
    output logic        coin_reject,
    output logic        vend_ok,
    output logic        vend_fail,
    output logic        change_valid,
    output logic [8:0]  change_cents,
    output logic        busy
);

    localparam logic [9:0] MAX_SUM = 10'(MAX_CENTS);

    typedef enum logic {
        COLLECT,
        CHANGE
    } state_t;

    state_t state;

    // Individual decimal digits back the packed coin_count so saturation
    // can be detected without decoding the packed value.
    logic [3:0] nickel_digit;
    logic [3:0] dime_digit;
    logic [3:0] quarter_digit;
    logic [3:0] dollar_digit;

    logic [9:0]  coin_value;
    logic [9:0]  coin_sum;
    logic [13:0] coin_weight;
    logic        digit_full;

    // Decode the presented coin: its value in cents, its weight in the
    // packed count, and whether its digit has already saturated.
    always_comb begin
        coin_value  = 10'd5;
        coin_weight = 14'd1;
        digit_full  = (nickel_digit == 4'd9);
        case (coin_type)
            2'b00: begin
                coin_value  = 10'd5;
                coin_weight = 14'd1;
                digit_full  = (nickel_digit == 4'd9);
            end
            2'b01: begin
                coin_value  = 10'd10;
                coin_weight = 14'd10;
                digit_full  = (dime_digit == 4'd9);
            end
            2'b10: begin
                coin_value  = 10'd25;
                coin_weight = 14'd100;
                digit_full  = (quarter_digit == 4'd9);
            end
            default: begin
                coin_value  = 10'd100;
                coin_weight = 14'd1000;
                digit_full  = (dollar_digit == 4'd9);
            end
        endcase
        coin_sum = {1'b0, credit} + coin_value;
    end

    // Both status outputs come straight from the state flop, so they are
    // registered and drop together the moment reset is asserted.
    assign change_valid = (state == CHANGE);
    assign busy         = (state == CHANGE);

    // Main controller: pulses default low each cycle; cancel outranks
    // vend_req, which outranks a coin, and a coin arriving alongside an
    // acting cancel or vend is refused.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= COLLECT;
            credit        <= '0;
            coin_count    <= '0;
            nickel_digit  <= '0;
            dime_digit    <= '0;
            quarter_digit <= '0;
            dollar_digit  <= '0;
            change_cents  <= '0;
            coin_accept   <= 1'b0;
            coin_reject   <= 1'b0;
            vend_ok       <= 1'b0;
            vend_fail     <= 1'b0;
        end else begin
            coin_accept <= 1'b0;
            coin_reject <= 1'b0;
            vend_ok     <= 1'b0;
            vend_fail   <= 1'b0;
            case (state)
                COLLECT: begin
                    if (cancel) begin
                        if (coin_valid) begin
                            coin_reject <= 1'b1;
                        end
                        if (credit != 9'd0) begin
                            change_cents  <= credit;
                            credit        <= '0;
                            coin_count    <= '0;
                            nickel_digit  <= '0;
                            dime_digit    <= '0;
                            quarter_digit <= '0;
                            dollar_digit  <= '0;
                            state         <= CHANGE;
                        end
                    end else if (vend_req) begin
                        if (coin_valid) begin
                            coin_reject <= 1'b1;
                        end
                        if (credit >= price) begin
                            vend_ok       <= 1'b1;
                            change_cents  <= credit - price;
                            credit        <= '0;
                            coin_count    <= '0;
                            nickel_digit  <= '0;
                            dime_digit    <= '0;
                            quarter_digit <= '0;
                            dollar_digit  <= '0;
                            if (credit != price) begin
                                state <= CHANGE;
                            end
                        end else begin
                            vend_fail <= 1'b1;
                        end
                    end else if (coin_valid) begin
                        if (coin_sum <= MAX_SUM) begin
                            coin_accept <= 1'b1;
                            credit      <= coin_sum[8:0];
                            if (!digit_full) begin
                                coin_count <= coin_count + coin_weight;
                                case (coin_type)
                                    2'b00:   nickel_digit  <= nickel_digit + 4'd1;
                                    2'b01:   dime_digit    <= dime_digit + 4'd1;
                                    2'b10:   quarter_digit <= quarter_digit + 4'd1;
                                    default: dollar_digit  <= dollar_digit + 4'd1;
                                endcase
                            end
                        end else begin
                            coin_reject <= 1'b1;
                        end
                    end
                end
                CHANGE: begin
                    if (coin_valid) begin
                        coin_reject <= 1'b1;
                    end
                    if (vend_req) begin
                        vend_fail <= 1'b1;
                    end
                    if (change_ack) begin
                        change_cents <= '0;
                        state        <= COLLECT;
                    end
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coin_accumulator.sv
// tb_coin_accumulator
// Directed self-checking bench for coin_accumulator with MAX_CENTS = 500.
// Inputs change on the falling edge; outputs are sampled 1 ns after the
// rising edge that consumed them.
module tb_coin_accumulator;

    localparam logic [1:0] NICKEL  = 2'b00;
    localparam logic [1:0] DIME    = 2'b01;
    localparam logic [1:0] QUARTER = 2'b10;
    localparam logic [1:0] DOLLAR  = 2'b11;

    logic        clk;
    logic        rst;
    logic        coin_valid;
    logic [1:0]  coin_type;
    logic        cancel;
    logic        vend_req;
    logic [8:0]  price;
    logic        change_ack;
    logic [8:0]  credit;
    logic [13:0] coin_count;
    logic        coin_accept;
    logic        coin_reject;
    logic        vend_ok;
    logic        vend_fail;
    logic        change_valid;
    logic [8:0]  change_cents;
    logic        busy;

    int checks;
    int errors;

    coin_accumulator #(.MAX_CENTS(500)) dut (
        .clk          (clk),
        .rst          (rst),
        .coin_valid   (coin_valid),
        .coin_type    (coin_type),
        .cancel       (cancel),
        .vend_req     (vend_req),
        .price        (price),
        .change_ack   (change_ack),
        .credit       (credit),
        .coin_count   (coin_count),
        .coin_accept  (coin_accept),
        .coin_reject  (coin_reject),
        .vend_ok      (vend_ok),
        .vend_fail    (vend_fail),
        .change_valid (change_valid),
        .change_cents (change_cents),
        .busy         (busy)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present one cycle's worth of inputs on the falling edge, then wait
    // until just after the rising edge that samples them.
    task automatic applyStimulus(input logic cv, input logic [1:0] ct,
                                 input logic cn, input logic vr,
                                 input logic [8:0] pr, input logic ack);
        @(negedge clk);
        coin_valid = cv;
        coin_type  = ct;
        cancel     = cn;
        vend_req   = vr;
        price      = pr;
        change_ack = ack;
        @(posedge clk);
        #1;
    endtask

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input int observed,
                               input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic idle();
        applyStimulus(1'b0, NICKEL, 1'b0, 1'b0, 9'd0, 1'b0);
    endtask

    task automatic insertCoin(input logic [1:0] ct);
        applyStimulus(1'b1, ct, 1'b0, 1'b0, 9'd0, 1'b0);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        coin_valid = 1'b0;
        coin_type  = NICKEL;
        cancel     = 1'b0;
        vend_req   = 1'b0;
        price      = 9'd0;
        change_ack = 1'b0;

        // Reset state
        @(posedge clk);
        #1;
        checkOutput("reset_credit", int'(credit), 0);
        checkOutput("reset_count", int'(coin_count), 0);
        checkOutput("reset_change_valid", int'(change_valid), 0);
        checkOutput("reset_change_cents", int'(change_cents), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_pulses", int'({coin_accept, coin_reject, vend_ok, vend_fail}), 0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back coins: dime, quarter, nickel, dollar
        insertCoin(DIME);
        checkOutput("dime_credit", int'(credit), 10);
        checkOutput("dime_accept", int'(coin_accept), 1);
        insertCoin(QUARTER);
        checkOutput("quarter_credit", int'(credit), 35);
        checkOutput("quarter_accept", int'(coin_accept), 1);
        insertCoin(NICKEL);
        checkOutput("nickel_credit", int'(credit), 40);
        checkOutput("nickel_accept", int'(coin_accept), 1);
        insertCoin(DOLLAR);
        checkOutput("dollar_credit", int'(credit), 140);
        checkOutput("dollar_accept", int'(coin_accept), 1);
        checkOutput("count_1111", int'(coin_count), 1111);
        idle();
        checkOutput("accept_drops", int'(coin_accept), 0);

        // Vend 125 from 140 leaves 15 change
        applyStimulus(1'b0, NICKEL, 1'b0, 1'b1, 9'd125, 1'b0);
        checkOutput("vend_ok", int'(vend_ok), 1);
        checkOutput("vend_change_valid", int'(change_valid), 1);
        checkOutput("vend_change_cents", int'(change_cents), 15);
        checkOutput("vend_credit", int'(credit), 0);
        checkOutput("vend_count", int'(coin_count), 0);
        checkOutput("vend_busy", int'(busy), 1);
        for (int i = 0; i < 3; i++) begin
            idle();
            checkOutput("hold_change_valid", int'(change_valid), 1);
            checkOutput("hold_change_cents", int'(change_cents), 15);
            checkOutput("hold_vend_ok_low", int'(vend_ok), 0);
        end
        applyStimulus(1'b0, NICKEL, 1'b0, 1'b0, 9'd0, 1'b1);
        checkOutput("ack_change_valid", int'(change_valid), 0);
        checkOutput("ack_change_cents", int'(change_cents), 0);
        checkOutput("ack_busy", int'(busy), 0);

        // Ceiling: build 495, quarter refused, nickel reaches 500
        insertCoin(DOLLAR);
        insertCoin(DOLLAR);
        insertCoin(DOLLAR);
        insertCoin(DOLLAR);
        insertCoin(QUARTER);
        insertCoin(QUARTER);
        insertCoin(QUARTER);
        insertCoin(DIME);
        insertCoin(DIME);
        checkOutput("build_495", int'(credit), 495);
        checkOutput("build_count", int'(coin_count), 4320);
        insertCoin(QUARTER);
        checkOutput("over_reject", int'(coin_reject), 1);
        checkOutput("over_accept", int'(coin_accept), 0);
        checkOutput("over_credit", int'(credit), 495);
        checkOutput("over_count", int'(coin_count), 4320);
        insertCoin(NICKEL);
        checkOutput("max_accept", int'(coin_accept), 1);
        checkOutput("max_credit", int'(credit), 500);
        checkOutput("max_count", int'(coin_count), 4321);

        // Cancel returns the full 500 as change
        applyStimulus(1'b0, NICKEL, 1'b1, 1'b0, 9'd0, 1'b0);
        checkOutput("cancel_change", int'(change_cents), 500);
        checkOutput("cancel_valid", int'(change_valid), 1);
        checkOutput("cancel_no_vend_ok", int'(vend_ok), 0);
        checkOutput("cancel_credit", int'(credit), 0);
        applyStimulus(1'b0, NICKEL, 1'b0, 1'b0, 9'd0, 1'b1);
        checkOutput("cancel_ack", int'(change_valid), 0);

        // Ten nickels: digit saturates at 9, all coins still accepted
        for (int i = 0; i < 10; i++) begin
            insertCoin(NICKEL);
        end
        checkOutput("ten_nickel_accept", int'(coin_accept), 1);
        checkOutput("ten_nickel_credit", int'(credit), 50);
        checkOutput("ten_nickel_count", int'(coin_count), 9);
        applyStimulus(1'b0, NICKEL, 1'b0, 1'b1, 9'd75, 1'b0);
        checkOutput("short_vend_fail", int'(vend_fail), 1);
        checkOutput("short_vend_ok", int'(vend_ok), 0);
        checkOutput("short_credit", int'(credit), 50);
        checkOutput("short_valid", int'(change_valid), 0);

        // Cancel + vend + coin together at credit 60
        insertCoin(DIME);
        checkOutput("credit_60", int'(credit), 60);
        checkOutput("count_19", int'(coin_count), 19);
        applyStimulus(1'b1, DOLLAR, 1'b1, 1'b1, 9'd10, 1'b0);
        checkOutput("prio_change", int'(change_cents), 60);
        checkOutput("prio_reject", int'(coin_reject), 1);
        checkOutput("prio_no_vend_ok", int'(vend_ok), 0);
        checkOutput("prio_no_vend_fail", int'(vend_fail), 0);
        checkOutput("prio_valid", int'(change_valid), 1);
        checkOutput("prio_credit", int'(credit), 0);
        insertCoin(QUARTER);
        checkOutput("change_coin_reject", int'(coin_reject), 1);
        checkOutput("change_coin_credit", int'(credit), 0);
        checkOutput("change_coin_valid", int'(change_valid), 1);
        applyStimulus(1'b0, NICKEL, 1'b0, 1'b1, 9'd0, 1'b0);
        checkOutput("change_vend_fail", int'(vend_fail), 1);
        checkOutput("change_vend_ok", int'(vend_ok), 0);
        checkOutput("change_vend_cents", int'(change_cents), 60);
        applyStimulus(1'b0, NICKEL, 1'b0, 1'b0, 9'd0, 1'b1);
        checkOutput("prio_ack", int'(change_valid), 0);

        // Reset while holding 35 cents of change
        insertCoin(QUARTER);
        insertCoin(DIME);
        applyStimulus(1'b0, NICKEL, 1'b1, 1'b0, 9'd0, 1'b0);
        checkOutput("pre_reset_cents", int'(change_cents), 35);
        checkOutput("pre_reset_busy", int'(busy), 1);
        idle();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_valid", int'(change_valid), 0);
        checkOutput("async_rst_cents", int'(change_cents), 0);
        checkOutput("async_rst_busy", int'(busy), 0);
        checkOutput("async_rst_credit", int'(credit), 0);
        @(negedge clk);
        rst = 1'b0;
        insertCoin(DIME);
        checkOutput("post_rst_credit", int'(credit), 10);
        checkOutput("post_rst_valid", int'(change_valid), 0);

        // Exact-price vend: credit 100, price 100, no change phase
        applyStimulus(1'b0, NICKEL, 1'b1, 1'b0, 9'd0, 1'b0);
        applyStimulus(1'b0, NICKEL, 1'b0, 1'b0, 9'd0, 1'b1);
        insertCoin(DOLLAR);
        checkOutput("exact_credit", int'(credit), 100);
        applyStimulus(1'b0, NICKEL, 1'b0, 1'b1, 9'd100, 1'b0);
        checkOutput("exact_vend_ok", int'(vend_ok), 1);
        checkOutput("exact_valid", int'(change_valid), 0);
        checkOutput("exact_busy", int'(busy), 0);
        checkOutput("exact_credit_clr", int'(credit), 0);
        checkOutput("exact_cents", int'(change_cents), 0);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/coin_accumulator.md
# coin_accumulator

Sequential credit accumulator for the vending datapath: accepts one coin per cycle (nickel, dime, quarter, dollar), keeps the running credit in cents, and processes vend and cancel requests against a price. Change amounts are produced as a 9-bit cents value with a valid/ack handshake. That value is sized to feed the existing cents-to-coin-breakdown converter directly. It also keeps a packed per-denomination count of inserted coins, in the same decimal-packed format that converter produces (dollars×1000 + quarters×100 + dimes×10 + nickels).

## Interface
Parameters:
- MAX_CENTS, 500, credit ceiling in cents; legal range 5..511.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- coin_valid  in  1  one-cycle strobe: a coin is presented.
- coin_type  in  2  coin denomination: 00 nickel = 5, 01 dime = 10, 10 quarter = 25, 11 dollar = 100.
- cancel  in  1  return all credit as change.
- vend_req  in  1  purchase request at `price`.
- price  in  9  item price in cents; sampled with `vend_req`.
- change_ack  in  1  downstream has taken `change_cents`.
- credit  out  9  current credit in cents.
- coin_count  out  14  packed count of coins inserted this session (D×1000 + Q×100 + d×10 + N), each digit 0..9.
- coin_accept  out  1  one-cycle pulse: coin added.
- coin_reject  out  1  one-cycle pulse: coin refused.
- vend_ok  out  1  one-cycle pulse: vend granted.
- vend_fail  out  1  one-cycle pulse: vend refused.
- change_valid  out  1  `change_cents` is valid; held until acked.
- change_cents  out  9  change amount in cents.
- busy  out  1  high while in the CHANGE state.

## Operation
- Two states: COLLECT and CHANGE. Reset enters COLLECT.
- Input priority within one cycle: `cancel` > `vend_req` > `coin_valid`. Only the highest-priority request acts.
- A coin presented in the same cycle as a `cancel` or `vend_req` that acts is rejected (`coin_reject`).

COLLECT state:
- **Coin:** with value v, compute sum = credit + v at 10 bits.
  - If sum ≤ MAX_CENTS: credit ← sum and `coin_accept` pulses. The matching `coin_count` digit increments, saturating at 9; saturation does not refuse the coin.
  - Otherwise: `coin_reject` pulses and credit is unchanged.
- **vend_req:**
  - If credit ≥ price: `vend_ok` pulses, change_cents ← credit − price, and credit and `coin_count` clear to 0. If the change is nonzero, go to CHANGE; if it is zero, stay in COLLECT with `change_valid` low.
  - If credit < price: `vend_fail` pulses and nothing else changes.
  - A price of 0 is legal: the whole credit becomes change.
- **cancel:**
  - If credit > 0: change_cents ← credit, credit and `coin_count` clear, go to CHANGE. No `vend_ok`.
  - If credit = 0: no effect.

CHANGE state:
- `change_valid` = 1 and `busy` = 1; `change_cents` is held stable.
- `coin_valid` → `coin_reject`. `vend_req` → `vend_fail`. `cancel` is ignored.
- `change_ack` high → return to COLLECT. `change_valid` drops and `change_cents` clears to 0 on that edge.
- `change_ack` outside CHANGE is ignored.

## Timing
- All outputs are registered. A request sampled on edge N shows its result (`credit`, `coin_count`, pulses, `change_valid`) after edge N; latency is 1 cycle.
- Each pulse output is high for exactly one cycle per sampled event. Back-to-back coins on consecutive cycles each get their own pulse.
- After `vend_ok` or a cancel, `change_valid` rises in the same cycle as the pulse. The minimum CHANGE dwell is 1 cycle, when `change_ack` is already high on the next edge.
- Reset values: credit 0, coin_count 0, change_cents 0, and all pulses, `change_valid` and `busy` at 0; state COLLECT.
- Reset mid-CHANGE discards the pending change with no residual `change_valid`.
- No combinational path from any input to any output.

## Test plan
- Reset, then dime, quarter, nickel, dollar on consecutive cycles → credit 10, 35, 40, 140; four `coin_accept` pulses; coin_count = 1111.
- Credit 140, vend_req with price 125 → `vend_ok`; change_valid = 1 with change_cents = 15; credit = 0; busy = 1. Hold change_ack low for 3 cycles → outputs stable. Ack → change_valid = 0 next cycle.
- Credit 495 (MAX_CENTS 500), insert quarter → `coin_reject`, credit stays 495. Insert nickel → credit 500.
- Ten nickels → credit 50, coin_count digit stays 9 (coin_count = 9). vend_req with price 75 → `vend_fail`, credit stays 50.
- Same cycle: cancel, vend_req and coin_valid, with credit 60 → change_cents = 60, `coin_reject` pulses, no `vend_ok`. While in CHANGE: a coin → reject, a vend → fail.
- Assert rst while in CHANGE with change_cents = 35 → all outputs 0 immediately; after release, accept a dime → credit 10. Exact-price vend (credit 100, price 100) → `vend_ok`, no change_valid.
